// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm controller: FSM states and BCD digit limits.
// ALARM_SNOOZE_EN adds the SNOOZE state; without it the encoding stops at RING.
package alarm_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET_H  = 3'd1;
  localparam logic [2:0] S_SET_M  = 3'd2;
  localparam logic [2:0] S_RING   = 3'd3;
  localparam logic [2:0] S_SNOOZE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SET_H = S_SET_H,
    ST_SET_M = S_SET_M,
    ST_RING  = S_RING
`ifdef ALARM_SNOOZE_EN
    , ST_SNOOZE = S_SNOOZE
`endif
  } state_t;

  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [2:0] MIN_TENS_MAX = 3'd5;
  // 23 split into tens/units digits
  localparam logic [1:0] HOUR_TENS_MAX = 2'd2;
  localparam logic [3:0] HOUR_UNIT_MAX = 4'd3;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Button/time/display bundle between the alarm controller and its surroundings.
// slave = alarm controller side, master = the driving side (clock core / test).
interface alarm_ctrl_if;
  logic       EN1HZ;
  logic       SIG2HZ;
  logic       MODE;
  logic       SELECT;
  logic       ADJUST;
  logic [3:0] SEC1;
  logic [2:0] SEC10;
  logic [3:0] MIN1;
  logic [2:0] MIN10;
  logic [3:0] HOUR1;
  logic [1:0] HOUR10;
  logic [3:0] AL_MIN1;
  logic [2:0] AL_MIN10;
  logic [3:0] AL_HOUR1;
  logic [1:0] AL_HOUR10;
  logic       ALMON;
  logic       MINON;
  logic       HOURON;
  logic       ARMED;
  logic       BUZZ;

  modport slave (
    input  EN1HZ, SIG2HZ, MODE, SELECT, ADJUST,
    input  SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10,
    output AL_MIN1, AL_MIN10, AL_HOUR1, AL_HOUR10,
    output ALMON, MINON, HOURON, ARMED, BUZZ
  );

  modport master (
    output EN1HZ, SIG2HZ, MODE, SELECT, ADJUST,
    output SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10,
    input  AL_MIN1, AL_MIN10, AL_HOUR1, AL_HOUR10,
    input  ALMON, MINON, HOURON, ARMED, BUZZ
  );
endinterface

// File: rtl/alarm_timer.sv
// Loadable seconds down-counter shared by RING and SNOOZE. o_expire is high
// for the single cycle in which a tick takes the count from 1 to 0.
module alarm_timer #(
  parameter int TW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_tick,
  output logic          o_expire
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                      r_cnt <= '0;
    else if (i_load)                   r_cnt <= i_load_val;
    else if (i_tick && r_cnt != '0)    r_cnt <= r_cnt - TW'(1);
  end

  // A load on the same cycle pre-empts the expiry
  assign o_expire = i_tick & ~i_load & (r_cnt == TW'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm time, arm/set/ring sequencing and display enables.
// Define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise ADJUST in RING stops it.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int TW         = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alarm_ctrl_if.slave  bus
);

  localparam logic [TW-1:0] RING_LD   = TW'(RING_SEC);
  localparam logic [TW-1:0] SNOOZE_LD = TW'(SNOOZE_MIN * 60);

  state_t        r_state, w_state_nxt;
  logic          r_armed, r_match_d;
  logic [1:0]    r_al_h10;
  logic [3:0]    r_al_h1;
  logic [2:0]    r_al_m10;
  logic [3:0]    r_al_m1;

  logic          w_match, w_hit, w_expire;
  logic          w_load, w_load_snz, w_armed_tgl, w_hr_inc, w_mn_inc;
  logic [TW-1:0] w_load_val;

  assign w_match = (bus.HOUR10 == r_al_h10) && (bus.HOUR1 == r_al_h1) &&
                   (bus.MIN10 == r_al_m10) && (bus.MIN1 == r_al_m1) &&
                   (bus.SEC10 == 3'd0) && (bus.SEC1 == 4'd0);
  // Rising edge of match only, so a held time fires once
  assign w_hit      = r_armed & w_match & ~r_match_d;
  assign w_load_val = w_load_snz ? SNOOZE_LD : RING_LD;

  alarm_timer #(.TW(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (bus.EN1HZ),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_snz  = 1'b0;
    w_armed_tgl = 1'b0;
    w_hr_inc    = 1'b0;
    w_mn_inc    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.MODE)        w_state_nxt = ST_SET_H;
        else if (bus.SELECT) w_armed_tgl = 1'b1;
        else if (w_hit) begin
          w_state_nxt = ST_RING;
          w_load      = 1'b1;
        end
      end
      ST_SET_H: begin
        if (bus.MODE)        w_state_nxt = ST_IDLE;
        else if (bus.SELECT) w_state_nxt = ST_SET_M;
        else if (bus.ADJUST) w_hr_inc    = 1'b1;
      end
      ST_SET_M: begin
        if (bus.MODE)        w_state_nxt = ST_IDLE;
        else if (bus.SELECT) w_state_nxt = ST_SET_H;
        else if (bus.ADJUST) w_mn_inc    = 1'b1;
      end
      ST_RING: begin
        if (bus.SELECT) w_state_nxt = ST_IDLE;
        else if (bus.ADJUST) begin
`ifdef ALARM_SNOOZE_EN
          w_state_nxt = ST_SNOOZE;
          w_load      = 1'b1;
          w_load_snz  = 1'b1;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
        else if (w_expire) w_state_nxt = ST_IDLE;
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (bus.SELECT) w_state_nxt = ST_IDLE;
        else if (w_expire) begin
          w_state_nxt = ST_RING;
          w_load      = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_armed   <= 1'b0;
      r_match_d <= 1'b0;
      r_al_h10  <= '0;
      r_al_h1   <= '0;
      r_al_m10  <= '0;
      r_al_m1   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_match_d <= w_match;
      if (w_armed_tgl) r_armed <= ~r_armed;
      if (w_hr_inc) begin
        if (r_al_h10 == HOUR_TENS_MAX && r_al_h1 == HOUR_UNIT_MAX) begin
          r_al_h10 <= '0;
          r_al_h1  <= '0;
        end else if (r_al_h1 == BCD_UNIT_MAX) begin
          r_al_h1  <= '0;
          r_al_h10 <= r_al_h10 + 2'd1;
        end else begin
          r_al_h1  <= r_al_h1 + 4'd1;
        end
      end
      // Minute wrap 59->00 never carries into the hour
      if (w_mn_inc) begin
        if (r_al_m1 == BCD_UNIT_MAX) begin
          r_al_m1  <= '0;
          r_al_m10 <= (r_al_m10 == MIN_TENS_MAX) ? 3'd0 : r_al_m10 + 3'd1;
        end else begin
          r_al_m1  <= r_al_m1 + 4'd1;
        end
      end
    end
  end

  assign bus.AL_HOUR10 = r_al_h10;
  assign bus.AL_HOUR1  = r_al_h1;
  assign bus.AL_MIN10  = r_al_m10;
  assign bus.AL_MIN1   = r_al_m1;
  assign bus.ARMED     = r_armed;
  assign bus.ALMON     = (r_state == ST_SET_H) || (r_state == ST_SET_M);
  assign bus.HOURON    = (r_state == ST_SET_H) ? bus.SIG2HZ : 1'b1;
  assign bus.MINON     = (r_state == ST_SET_M) ? bus.SIG2HZ : 1'b1;
  assign bus.BUZZ      = (r_state == ST_RING) & bus.SIG2HZ;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: each driven cycle pushes the modelled output
// vector, which is popped and compared one cycle later. Honours ALARM_SNOOZE_EN.
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_ctrl_if ifc();

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_MIN(5), .TW(10)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  // model: 0 idle, 1 set_h, 2 set_m, 3 ring, 4 snooze
  int m_st, m_h, m_m;
  bit m_armed;
  int n_chk, n_fail;
  logic [17:0] sb[$];
  logic [17:0] e, o;

  function automatic logic [17:0] exp_vec();
    logic s;
    s = ifc.SIG2HZ;
    return {(m_st == 1) || (m_st == 2), m_armed, (m_st == 3) & s,
            (m_st == 1) ? s : 1'b1, (m_st == 2) ? s : 1'b1,
            2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10)};
  endfunction

  function automatic logic [17:0] obs();
    return {ifc.ALMON, ifc.ARMED, ifc.BUZZ, ifc.HOURON, ifc.MINON,
            ifc.AL_HOUR10, ifc.AL_HOUR1, ifc.AL_MIN10, ifc.AL_MIN1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ifc.MODE = 1'b0; ifc.SELECT = 1'b0; ifc.ADJUST = 1'b0; ifc.EN1HZ = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    ifc.HOUR10 = 2'(h / 10); ifc.HOUR1 = 4'(h % 10);
    ifc.MIN10  = 3'(m / 10); ifc.MIN1  = 4'(m % 10);
    ifc.SEC10  = 3'(s / 10); ifc.SEC1  = 4'(s % 10);
  endtask

  // stimulus only: walk the running time onto the alarm edge
  task automatic go_ring();
    set_time(7, 29, 59); step();
    set_time(7, 30, 0);  step();
    m_st = 3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifc.SIG2HZ = 1'b1;
    m_st = 0; m_h = 0; m_m = 0; m_armed = 0;
    sb.push_back(exp_vec()); step(); rst_n = 1'b1;
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL reset: got %h want %h", o, e); end
  endtask

  task automatic test_hour_wrap();
    ifc.MODE = 1'b1; m_st = 1;
    sb.push_back(exp_vec()); step();
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL enter_set_h: got %h want %h", o, e); end
    for (int i = 1; i <= 24; i++) begin
      ifc.ADJUST = 1'b1; ifc.SIG2HZ = ~ifc.SIG2HZ; m_h = (m_h + 1) % 24;
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL hour_inc%0d: got %h want %h", i, o, e); end
    end
    ifc.MODE = 1'b1; m_st = 0;
    sb.push_back(exp_vec()); step();
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL leave_set_h: got %h want %h", o, e); end
  endtask

  task automatic test_minute_wrap();
    // 0:mode, 1..7 hour adj, 8 select, 9..67 min adj to 59, 68 wrap, 69..98 to :30, 99 mode
    for (int i = 0; i <= 99; i++) begin
      ifc.SIG2HZ = ~ifc.SIG2HZ;
      if (i == 0)        begin ifc.MODE = 1'b1;   m_st = 1; end
      else if (i <= 7)   begin ifc.ADJUST = 1'b1; m_h = m_h + 1; end
      else if (i == 8)   begin ifc.SELECT = 1'b1; m_st = 2; end
      else if (i <= 98)  begin ifc.ADJUST = 1'b1; m_m = (m_m + 1) % 60; end
      else               begin ifc.MODE = 1'b1;   m_st = 0; end
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL min_edit%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      begin ifc.MODE = 1'b1; ifc.SELECT = 1'b1; m_st = 1; end
      else if (i == 1) begin ifc.MODE = 1'b1; m_st = 0; end
      else             begin ifc.SELECT = 1'b1; m_armed = 1; end
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL priority%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_ring();
    set_time(7, 29, 59); step();
    set_time(7, 30, 0); ifc.SIG2HZ = 1'b1; m_st = 3;
    sb.push_back(exp_vec()); step();
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL ring_hit: got %h want %h", o, e); end
    for (int i = 1; i <= 60; i++) begin
      ifc.EN1HZ = 1'b1; ifc.SIG2HZ = ~ifc.SIG2HZ;
      if (i == 60) m_st = 0;
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL ring_sec%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_hold_once();
    go_ring(); ifc.SIG2HZ = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) begin ifc.SELECT = 1'b1; m_st = 0; end
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL hold_once%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_disarmed();
    ifc.SELECT = 1'b1; m_armed = 0; set_time(7, 29, 59);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) set_time(7, 30, 0);
      if (i == 7) begin ifc.SELECT = 1'b1; m_armed = 1; end
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL disarmed%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_edit_match();
    set_time(7, 29, 59);
    for (int i = 0; i < 5; i++) begin
      ifc.SIG2HZ = ~ifc.SIG2HZ;
      if (i == 0)      begin ifc.MODE = 1'b1; m_st = 1; end
      else if (i == 1) begin ifc.SELECT = 1'b1; m_st = 2; end
      else if (i == 2) set_time(7, 30, 0);
      else if (i == 3) begin ifc.MODE = 1'b1; m_st = 0; end
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL edit_match%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_snooze();
    go_ring(); ifc.SIG2HZ = 1'b1;
`ifdef ALARM_SNOOZE_EN
    ifc.ADJUST = 1'b1; m_st = 4;
    sb.push_back(exp_vec()); step();
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL snooze_enter: got %h want %h", o, e); end
    for (int i = 1; i <= 300; i++) begin
      ifc.EN1HZ = 1'b1; ifc.SIG2HZ = ~ifc.SIG2HZ;
      if (i == 300) m_st = 3;
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_sec%0d: got %h want %h", i, o, e); end
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin ifc.ADJUST = 1'b1; m_st = 4; end
      else        begin ifc.SELECT = 1'b1; m_st = 0; end
      sb.push_back(exp_vec()); step();
      o = obs(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL snooze_cancel%0d: got %h want %h", i, o, e); end
    end
`else
    ifc.ADJUST = 1'b1; m_st = 0;
    sb.push_back(exp_vec()); step();
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL adjust_stops_ring: got %h want %h", o, e); end
`endif
  endtask

  task automatic test_reset_ring();
    go_ring(); ifc.SIG2HZ = 1'b1;
    sb.push_back(exp_vec()); step();
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL pre_reset_ring: got %h want %h", o, e); end
    rst_n = 1'b0; m_st = 0; m_h = 0; m_m = 0; m_armed = 0;
    sb.push_back(exp_vec()); step(); rst_n = 1'b1;
    o = obs(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL reset_in_ring: got %h want %h", o, e); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ifc.EN1HZ = 1'b0; ifc.SIG2HZ = 1'b1;
    ifc.MODE = 1'b0; ifc.SELECT = 1'b0; ifc.ADJUST = 1'b0;
    set_time(12, 0, 0);
    #1;
    test_reset();
    test_hour_wrap();
    test_minute_wrap();
    test_priority();
    test_ring();
    test_hold_once();
    test_disarmed();
    test_edit_match();
    test_snooze();
    test_reset_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
